// File: rtl/wb_byte_master_pkg.sv
// Shared command/response codes and FSM state type for the byte-stream Wishbone initiator.
package wb_byte_master_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP
  } state_e;

  // Index of the final response byte: a successful read returns 'K' plus four data bytes.
  function automatic logic [2:0] rsp_last(input logic is_rd, input logic err);
    return (is_rd && !err) ? 3'd4 : 3'd0;
  endfunction

endpackage

// File: rtl/wb_byte_master.sv
// Framed UART command bytes in, single 32-bit Wishbone read/write cycles out,
// with a status byte (plus read data) returned to the UART transmitter.
module wb_byte_master
  import wb_byte_master_pkg::*;
#(
  parameter int BUS_TIMEOUT = 1024,
  parameter int RX_TIMEOUT  = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  output logic        busy
);

  localparam int RX_W  = $clog2(RX_TIMEOUT + 1);
  localparam int BUS_W = $clog2(BUS_TIMEOUT + 1);
  localparam logic [RX_W-1:0]  RX_LAST  = RX_W'(RX_TIMEOUT - 1);
  localparam logic [BUS_W-1:0] BUS_LAST = BUS_W'(BUS_TIMEOUT - 1);

  state_e            state_q,    state_d;
  logic              is_wr_q,    is_wr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [RX_W-1:0]   rx_cnt_q,   rx_cnt_d;
  logic [BUS_W-1:0]  bus_cnt_q,  bus_cnt_d;
  logic [2:0]        rsp_idx_q,  rsp_idx_d;
  logic              err_q,      err_d;
  logic [31:0]       adr_q,      adr_d;
  logic [31:0]       dat_q,      dat_d;
  logic [31:0]       rdata_q,    rdata_d;
  logic              cyc_q,      cyc_d;
  logic              we_q,       we_d;
  logic              tx_wr_q,    tx_wr_d;
  logic [7:0]        tx_data_q,  tx_data_d;

  function automatic logic [7:0] rsp_byte(input logic [2:0] idx, input logic err,
                                          input logic [31:0] rdata);
    logic [7:0] b;
    case (idx)
      3'd0:    b = err ? RSP_ERR : RSP_OK;
      3'd1:    b = rdata[31:24];
      3'd2:    b = rdata[23:16];
      3'd3:    b = rdata[15:8];
      default: b = rdata[7:0];
    endcase
    return b;
  endfunction

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    byte_cnt_d = byte_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    bus_cnt_d  = bus_cnt_q;
    rsp_idx_d  = rsp_idx_q;
    err_d      = err_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rdata_d    = rdata_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    tx_wr_d    = 1'b0;
    tx_data_d  = tx_data_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
          is_wr_d    = (rx_data == CMD_WR);
          byte_cnt_d = 2'd0;
          rx_cnt_d   = '0;
          state_d    = S_ADDR;
        end
      end

      S_ADDR, S_WDATA: begin
        if (rx_valid) begin
          rx_cnt_d   = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (state_q == S_ADDR) adr_d = {adr_q[23:0], rx_data};
          else                   dat_d = {dat_q[23:0], rx_data};
          if (byte_cnt_q == 2'd3) begin
            if (state_q == S_ADDR && is_wr_q) begin
              state_d = S_WDATA;
            end else begin
              // Last frame byte: launch the bus cycle on this same edge.
              state_d   = S_BUS;
              cyc_d     = 1'b1;
              we_d      = is_wr_q;
              bus_cnt_d = '0;
            end
          end
        end else if (rx_cnt_q == RX_LAST) begin
          state_d = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + RX_W'(1);
        end
      end

      S_BUS: begin
        // Ack is tested first so it wins over a coincident timeout.
        if (wb_ack_i) begin
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          err_d     = 1'b0;
          rdata_d   = wb_dat_i;
          rsp_idx_d = 3'd0;
          state_d   = S_RESP;
        end else if (bus_cnt_q == BUS_LAST) begin
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          err_d     = 1'b1;
          rsp_idx_d = 3'd0;
          state_d   = S_RESP;
        end else begin
          bus_cnt_d = bus_cnt_q + BUS_W'(1);
        end
      end

      S_RESP: begin
        // The tx_wr_q term leaves a guard cycle for a transmitter whose busy flag lags a cycle.
        if (!tx_busy && !tx_wr_q) begin
          tx_wr_d   = 1'b1;
          tx_data_d = rsp_byte(rsp_idx_q, err_q, rdata_q);
          rsp_idx_d = rsp_idx_q + 3'd1;
          if (rsp_idx_q == rsp_last(!is_wr_q, err_q)) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_wr_q    <= 1'b0;
      byte_cnt_q <= 2'd0;
      rx_cnt_q   <= '0;
      bus_cnt_q  <= '0;
      rsp_idx_q  <= 3'd0;
      err_q      <= 1'b0;
      adr_q      <= 32'd0;
      dat_q      <= 32'd0;
      rdata_q    <= 32'd0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      tx_wr_q    <= 1'b0;
      tx_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      byte_cnt_q <= byte_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      bus_cnt_q  <= bus_cnt_d;
      rsp_idx_q  <= rsp_idx_d;
      err_q      <= err_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      rdata_q    <= rdata_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      tx_wr_q    <= tx_wr_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign wb_adr_o = adr_q & 32'hFFFF_FFFC;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = 4'hF;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign tx_wr    = tx_wr_q;
  assign tx_data  = tx_data_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_byte_master.sv
// Directed bench for wb_byte_master: frame-level model of expected bus cycles and reply bytes,
// a model slave with programmable ack delay, and a UART stub whose busy flag rises a cycle late.
module tb_wb_byte_master;

  localparam int BT = 16;
  localparam int RT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
  logic        busy;

  always #5 clk = ~clk;

  wb_byte_master #(.BUS_TIMEOUT(BT), .RX_TIMEOUT(RT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    int          len;
  } bus_t;

  bus_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic [31:0] last_adr, last_dat;
  logic        last_we;
  int          last_len;

  // Slave: acks on the (slv_delay+1)-th cycle of cyc; a delay >= BT means never.
  int          slv_delay = 0;
  logic [31:0] slv_rdata = 32'd0;
  int          slv_cnt = 0;
  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (wb_cyc_o && wb_stb_o && !reset) begin
        if (slv_cnt == slv_delay) begin
          wb_ack_i = 1'b1;
          wb_dat_i = slv_rdata;
        end else begin
          wb_ack_i = 1'b0;
        end
        slv_cnt++;
      end else begin
        wb_ack_i = 1'b0;
        slv_cnt  = 0;
      end
    end
  end

  // UART stub: busy rises the cycle after tx_wr and holds for 4 cycles.
  int pend = 0;
  int bt = 0;
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (pend != 0) begin
        tx_busy = 1'b1;
        bt = 4;
        pend = 0;
      end else if (bt > 0) begin
        bt--;
        if (bt == 0) tx_busy = 1'b0;
      end
      if (tx_wr) pend = 1;
    end
  end

  // Compare process: every cycle on the falling edge.
  logic prev_cyc = 1'b0;
  logic prev_tx_wr = 1'b0;
  int   cyc_len = 0;
  bus_t cur;
  always @(negedge clk) begin
    if (reset) begin
      prev_cyc   = 1'b0;
      prev_tx_wr = 1'b0;
      cyc_len    = 0;
    end else begin
      if (wb_cyc_o) begin
        if (!prev_cyc) chk("cyc_expected", 32'(exp_bus.size() != 0), 32'd1);
        if (exp_bus.size() != 0) begin
          chk("adr", wb_adr_o, exp_bus[0].adr);
          chk("we", 32'(wb_we_o), 32'(exp_bus[0].we));
          chk("sel", 32'(wb_sel_o), 32'hF);
          chk("stb", 32'(wb_stb_o), 32'd1);
          if (exp_bus[0].we) chk("wdat", wb_dat_o, exp_bus[0].dat);
        end
        last_adr = wb_adr_o;
        last_dat = wb_dat_o;
        last_we  = wb_we_o;
        cyc_len++;
      end else if (prev_cyc) begin
        chk("stb_drop", 32'(wb_stb_o), 32'd0);
        if (exp_bus.size() != 0) begin
          cur = exp_bus.pop_front();
          chk("cyc_len", 32'(cyc_len), 32'(cur.len));
        end
        last_len = cyc_len;
        cyc_len  = 0;
      end
      if (tx_wr) begin
        chk("tx_guard", {30'd0, prev_tx_wr, tx_busy}, 32'd0);
        chk("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
        if (exp_tx.size() != 0) chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
        tx_log.push_back(tx_data);
      end
      prev_cyc   = wb_cyc_o;
      prev_tx_wr = tx_wr;
    end
  end

  // Called at posedge+1; leaves the bench at posedge+1 of the cycle after the byte (plus gap).
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input string nm);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy && exp_tx.size() == 0 && exp_bus.size() == 0) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk(nm, 32'(ok), 32'd1);
    repeat (6) begin @(posedge clk); #1; end
  endtask

  task automatic run_frame(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input int delay, input logic [31:0] rdata, input bit inject);
    bus_t b;
    logic [7:0] bytes[$];
    slv_delay = delay;
    slv_rdata = rdata;
    b.adr = adr & 32'hFFFF_FFFC;
    b.dat = dat;
    b.we  = we;
    b.len = (delay < BT) ? delay + 1 : BT;
    exp_bus.push_back(b);
    if (delay >= BT) begin
      exp_tx.push_back(8'h45);
    end else begin
      exp_tx.push_back(8'h4B);
      if (!we) for (int i = 3; i >= 0; i--) exp_tx.push_back(rdata[8*i +: 8]);
    end
    tx_log.delete();
    bytes.push_back(we ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) bytes.push_back(adr[8*i +: 8]);
    if (we) for (int i = 3; i >= 0; i--) bytes.push_back(dat[8*i +: 8]);
    for (int i = 0; i < bytes.size(); i++)
      send_byte(bytes[i], (i == bytes.size() - 1) ? 0 : ((i % 3 == 1) ? 2 : 0));
    chk("cyc_latency", 32'(wb_cyc_o), 32'd1);
    if (inject) begin
      for (int i = 0; i < BT + 4 && wb_cyc_o; i++) begin @(posedge clk); #1; end
      for (int i = 0; i < 3; i++) begin
        chk("inject_in_resp", {30'd0, wb_cyc_o, busy}, 32'd1);
        send_byte((i == 0) ? 8'h57 : 8'h00, 1);
      end
    end
    wait_done("frame_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_tx_wr", 32'(tx_wr), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'hF);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Write with ack two cycles after stb.
    run_frame(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2, 32'd0, 1'b0);
    chk("w_adr", last_adr, 32'h8000_0010);
    chk("w_dat", last_dat, 32'hDEAD_BEEF);
    chk("w_we", 32'(last_we), 32'd1);
    chk("w_len", 32'(last_len), 32'd3);
    chk("w_tx_n", 32'(tx_log.size()), 32'd1);
    chk("w_tx0", 32'(tx_log[0]), 32'h4B);

    // Zero-wait read.
    run_frame(1'b0, 32'h0000_0004, 32'd0, 0, 32'h1234_5678, 1'b0);
    chk("r_we", 32'(last_we), 32'd0);
    chk("r_len", 32'(last_len), 32'd1);
    chk("r_tx_n", 32'(tx_log.size()), 32'd5);
    chk("r_tx0", 32'(tx_log[0]), 32'h4B);
    chk("r_txdata", {tx_log[1], tx_log[2], tx_log[3], tx_log[4]}, 32'h1234_5678);

    // Never-acked read: bus timeout.
    run_frame(1'b0, 32'h0000_0008, 32'd0, 99, 32'hFFFF_FFFF, 1'b0);
    chk("to_len", 32'(last_len), 32'd16);
    chk("to_tx_n", 32'(tx_log.size()), 32'd1);
    chk("to_tx0", 32'(tx_log[0]), 32'h45);

    // Ack on the 16th cycle beats the timeout.
    run_frame(1'b1, 32'h0000_000C, 32'h0A0B_0C0D, 15, 32'd0, 1'b0);
    chk("ack16_len", 32'(last_len), 32'd16);
    chk("ack16_tx0", 32'(tx_log[0]), 32'h4B);

    // Unknown command byte is ignored.
    tx_log.delete();
    send_byte(8'h33, 0);
    for (int i = 0; i < 5; i++) begin
      chk("badcmd_busy", {30'd0, busy, wb_cyc_o}, 32'd0);
      @(posedge clk); #1;
    end

    // Partial frame then silence: dropped after RT idle cycles.
    send_byte(8'h57, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    chk("rxto_busy_start", 32'(busy), 32'd1);
    repeat (RT - 1) begin @(posedge clk); #1; end
    chk("rxto_busy_last", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("rxto_idle", {30'd0, busy, wb_cyc_o}, 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    chk("rxto_no_tx", 32'(tx_log.size()), 32'd0);
    run_frame(1'b1, 32'h2000_0000, 32'h55AA_33CC, 1, 32'd0, 1'b0);
    chk("rxto_next_adr", last_adr, 32'h2000_0000);
    chk("rxto_next_dat", last_dat, 32'h55AA_33CC);

    // Bytes arriving during the response are dropped.
    run_frame(1'b0, 32'h0000_0010, 32'd0, 0, 32'hCAFE_F00D, 1'b1);
    chk("ovr_busy", 32'(busy), 32'd0);
    chk("ovr_tx_n", 32'(tx_log.size()), 32'd5);
    chk("ovr_txdata", {tx_log[1], tx_log[2], tx_log[3], tx_log[4]}, 32'hCAFE_F00D);

    // Reset while the bus cycle is outstanding.
    begin
      bus_t b;
      b.adr = 32'h0000_0014; b.dat = 32'd0; b.we = 1'b0; b.len = 0;
      exp_bus.push_back(b);
      slv_delay = 99;
      send_byte(8'h52, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h14, 0);
      chk("rstmid_cyc_up", 32'(wb_cyc_o), 32'd1);
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
      exp_bus.delete();
      @(posedge clk); #1;
      chk("rstmid_drop", {28'd0, wb_cyc_o, wb_stb_o, tx_wr, busy}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (20) begin @(posedge clk); #1; end
    end
    run_frame(1'b0, 32'h0000_0018, 32'd0, 1, 32'h0BAD_F00D, 1'b0);
    chk("post_rst_txdata", {tx_log[1], tx_log[2], tx_log[3], tx_log[4]}, 32'h0BAD_F00D);

    chk("end_bus_q", 32'(exp_bus.size()), 32'd0);
    chk("end_tx_q", 32'(exp_tx.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
